// File: rtl/uart_pkg.sv
// Shared UART package: RX/TX state encodings, frame geometry constants and
// a 2-of-3 majority helper used by the receiver's optional sample voting.
package uart_pkg;

   localparam int UART_DATA_BITS  = 8;
   localparam int UART_OVERSAMPLE = 16;

   // Oversample count at the middle of the start bit.
   localparam logic [3:0] RX_MID_START = 4'd7;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_t;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input. The reset value
// is a parameter so idle-high and idle-low inputs both come out of reset at
// their idle level.
module uart_rx_sync #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // Two register stages to let a metastable first stage resolve.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling.
// Optional feature macro: UART_RX_MAJORITY_EN -- when defined, every sample
// (start validation, data, stop) is the 2-of-3 vote of the current and two
// previous tick samples; when undefined the raw synchronized sample is used.
//
// Output protocol: rx_valid and rx_frame_err are one-cycle strobes with no
// back-pressure (there is no ready). rx_data is valid while rx_valid is high
// and is held until the next good frame; a consumer must take it then or
// later, but it never changes on a framing error. The two strobes are never
// high together. dbg_state exposes the receiver state encoding.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = UART_DATA_BITS,
   parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tick16,
   input  logic                 rx_line,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 rx_frame_err,
   output logic                 rx_busy,
   output logic [1:0]           dbg_state
);

   localparam logic [3:0] OS_LAST  = 4'(OVERSAMPLE - 1);
   localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

   rx_state_t            state;
   logic                 armed;
   logic [3:0]           os_cnt;
   logic [2:0]           bit_idx;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 rx_s;
   logic                 rx_sample;

   uart_rx_sync #(
      .RST_VAL (1'b1)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx_line),
      .q   (rx_s)
   );

`ifdef UART_RX_MAJORITY_EN
   logic [1:0] hist;

   // Keep the two previous tick samples for the majority vote.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist <= 2'b11;
      end else if (tick16) begin
         hist <= {hist[0], rx_s};
      end
   end

   assign rx_sample = maj3(rx_s, hist[0], hist[1]);
`else
   assign rx_sample = rx_s;
`endif

   assign dbg_state = state;

   // Receive state machine; all counters advance only on tick16 cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= RX_IDLE;
         armed        <= 1'b1;
         os_cnt       <= 4'd0;
         bit_idx      <= 3'd0;
         shift_reg    <= '0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         rx_frame_err <= 1'b0;
         rx_busy      <= 1'b0;
      end else begin
         rx_valid     <= 1'b0;
         rx_frame_err <= 1'b0;
         case (state)
            RX_IDLE: begin
               rx_busy <= 1'b0;
               if (tick16) begin
                  if (rx_s) begin
                     // Line seen high: a new start edge may be accepted.
                     armed <= 1'b1;
                  end else if (armed) begin
                     os_cnt  <= 4'd0;
                     rx_busy <= 1'b1;
                     state   <= RX_START;
                  end
               end
            end
            RX_START: begin
               if (tick16) begin
                  if (os_cnt == RX_MID_START) begin
                     if (rx_sample) begin
                        // Line back high at mid start bit: glitch, not a frame.
                        rx_busy <= 1'b0;
                        state   <= RX_IDLE;
                     end else begin
                        os_cnt  <= 4'd0;
                        bit_idx <= 3'd0;
                        state   <= RX_DATA;
                     end
                  end else begin
                     os_cnt <= os_cnt + 4'd1;
                  end
               end
            end
            RX_DATA: begin
               if (tick16) begin
                  os_cnt <= os_cnt + 4'd1;
                  if (os_cnt == OS_LAST) begin
                     shift_reg <= {rx_sample, shift_reg[DATA_BITS-1:1]};
                     if (bit_idx == BIT_LAST) begin
                        state <= RX_STOP;
                     end else begin
                        bit_idx <= bit_idx + 3'd1;
                     end
                  end
               end
            end
            RX_STOP: begin
               if (tick16) begin
                  os_cnt <= os_cnt + 4'd1;
                  if (os_cnt == OS_LAST) begin
                     if (rx_sample) begin
                        rx_data  <= shift_reg;
                        rx_valid <= 1'b1;
                     end else begin
                        // Break or noise: wait for an idle-high tick first.
                        rx_frame_err <= 1'b1;
                        armed        <= 1'b0;
                     end
                     rx_busy <= 1'b0;
                     state   <= RX_IDLE;
                  end
               end
            end
            default: begin
               rx_busy <= 1'b0;
               state   <= RX_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios plus random frames, scored against a
// frame-level expectation queue (event kind, data, stop-sampling tick index).
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick16;
   logic       rx_line;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_frame_err;
   logic       rx_busy;
   logic [1:0] dbg_state;

   int checks   = 0;
   int failures = 0;
   int tick_no  = 0;
   logic [7:0] last_good;

   // Event word: {is_frame_err, rx_data, tick index of the stop sample}.
   logic [40:0] exp_q[$];
   logic [40:0] act_q[$];

`ifdef UART_RX_MAJORITY_EN
   localparam logic [7:0] GLITCH_EXP = 8'h0F;
`else
   localparam logic [7:0] GLITCH_EXP = 8'h07;
`endif

   always #5 clk = ~clk;

   uart_rx dut (
      .clk          (clk),
      .rst          (rst),
      .tick16       (tick16),
      .rx_line      (rx_line),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_frame_err (rx_frame_err),
      .rx_busy      (rx_busy),
      .dbg_state    (dbg_state)
   );

   task automatic chk(input string tag, input logic [40:0] obs, input logic [40:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Record every strobe with the tick index of the sample that caused it.
   always @(negedge clk) begin
      if (rst === 1'b0 && (rx_valid === 1'b1 || rx_frame_err === 1'b1)) begin
         act_q.push_back({rx_frame_err, rx_data, 32'(tick_no)});
         chk("strobes_exclusive", {40'd0, rx_valid & rx_frame_err}, 41'd0);
         if (rx_valid === 1'b1) chk("busy_low_with_valid", {40'd0, rx_busy}, 41'd0);
      end
   end

   // One bit-time slot of 1/16 bit: line changes, synchronizer settles, tick.
   task automatic slot(input logic v);
      @(negedge clk);
      tick16  = 1'b0;
      rx_line = v;
      repeat (2 + $urandom_range(0, 1)) @(negedge clk);
      tick16 = 1'b1;
      tick_no++;
   endtask

   task automatic settle();
      @(negedge clk);
      tick16 = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   // Send the first n slots of a frame; slot index glitch is inverted.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int glitch, input int n);
      logic v;
      for (int i = 0; i < n; i++) begin
         if (i < 16) v = 1'b0;
         else if (i < 144) v = b[3'((i - 16) / 16)];
         else v = stop_bit;
         if (i == glitch) v = ~v;
         slot(v);
      end
   endtask

   // Next slot is the start edge; stop is sampled 152 ticks after it.
   task automatic expect_frame(input logic [7:0] data, input logic stop_ok);
      if (stop_ok) begin
         exp_q.push_back({1'b0, data, 32'(tick_no + 153)});
         last_good = data;
      end else begin
         exp_q.push_back({1'b1, last_good, 32'(tick_no + 153)});
      end
   endtask

   task automatic check_events(input string tag);
      logic [40:0] e;
      logic [40:0] a;
      while (exp_q.size() > 0 || act_q.size() > 0) begin
         e = '0;
         a = '0;
         if (exp_q.size() > 0) e = exp_q.pop_front();
         if (act_q.size() > 0) a = act_q.pop_front();
         chk(tag, a, e);
      end
   endtask

   initial begin
      logic [7:0] b;
      logic       ok;
      logic       prev_bad;
      int         gap;

      rst = 1'b1; tick16 = 1'b0; rx_line = 1'b1; last_good = 8'h00;
      repeat (3) @(negedge clk);
      chk("reset_rx_data",   {33'd0, rx_data}, 41'd0);
      chk("reset_rx_valid",  {40'd0, rx_valid}, 41'd0);
      chk("reset_frame_err", {40'd0, rx_frame_err}, 41'd0);
      chk("reset_rx_busy",   {40'd0, rx_busy}, 41'd0);
      chk("reset_state",     {39'd0, dbg_state}, 41'd0);
      rst = 1'b0;
      repeat (20) slot(1'b1);

      // Good frame.
      expect_frame(8'hA5, 1'b1);
      send_frame(8'hA5, 1'b1, -1, 160);
      repeat (4) slot(1'b1);
      settle();
      check_events("good_a5");
      chk("good_a5_data", {33'd0, rx_data}, {33'd0, 8'hA5});
      chk("good_a5_busy", {40'd0, rx_busy}, 41'd0);

      // Start glitch: 4 low ticks, rejected at mid start bit.
      repeat (10) slot(1'b1);
      repeat (4) slot(1'b0);
      settle();
      chk("glitch_busy_high", {40'd0, rx_busy}, 41'd1);
      repeat (12) slot(1'b1);
      settle();
      chk("glitch_busy_low", {40'd0, rx_busy}, 41'd0);
      chk("glitch_state_idle", {39'd0, dbg_state}, 41'd0);
      chk("glitch_no_strobe", 41'(act_q.size()), 41'd0);
      chk("glitch_data_kept", {33'd0, rx_data}, {33'd0, 8'hA5});

      // Framing error, line held low, then recovery.
      expect_frame(8'h3C, 1'b0);
      send_frame(8'h3C, 1'b0, -1, 160);
      repeat (40) slot(1'b0);
      settle();
      chk("ferr_busy_low", {40'd0, rx_busy}, 41'd0);
      chk("ferr_data_kept", {33'd0, rx_data}, {33'd0, 8'hA5});
      check_events("frame_err");
      repeat (5) slot(1'b1);
      expect_frame(8'h3C, 1'b1);
      send_frame(8'h3C, 1'b1, -1, 160);
      repeat (4) slot(1'b1);
      settle();
      check_events("rearm_3c");

      // Back-to-back frames with one stop bit.
      expect_frame(8'h00, 1'b1);
      send_frame(8'h00, 1'b1, -1, 160);
      expect_frame(8'hFF, 1'b1);
      send_frame(8'hFF, 1'b1, -1, 160);
      repeat (4) slot(1'b1);
      settle();
      if (act_q.size() >= 2)
         chk("b2b_spacing", {9'd0, act_q[1][31:0] - act_q[0][31:0]}, 41'd160);
      check_events("back_to_back");

      // Reset during bit 4 of 0x55.
      send_frame(8'h55, 1'b1, -1, 88);
      @(negedge clk);
      tick16 = 1'b0;
      chk("midframe_busy", {40'd0, rx_busy}, 41'd1);
      rst = 1'b1;
      #1;
      chk("rst_mid_rx_data",   {33'd0, rx_data}, 41'd0);
      chk("rst_mid_rx_valid",  {40'd0, rx_valid}, 41'd0);
      chk("rst_mid_frame_err", {40'd0, rx_frame_err}, 41'd0);
      chk("rst_mid_rx_busy",   {40'd0, rx_busy}, 41'd0);
      chk("rst_mid_state",     {39'd0, dbg_state}, 41'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      last_good = 8'h00;
      repeat (4) slot(1'b1);
      expect_frame(8'h81, 1'b1);
      send_frame(8'h81, 1'b1, -1, 160);
      repeat (4) slot(1'b1);
      settle();
      check_events("after_reset_81");
      chk("after_reset_data", {33'd0, rx_data}, {33'd0, 8'h81});

      // Single-tick glitch at the bit-3 sample point of 0x0F.
      repeat (4) slot(1'b1);
      expect_frame(GLITCH_EXP, 1'b1);
      send_frame(8'h0F, 1'b1, 72, 160);
      repeat (4) slot(1'b1);
      settle();
      check_events("bit3_glitch");

      // Random frames, random gaps, occasional bad stop bit.
      prev_bad = 1'b0;
      for (int n = 0; n < 12; n++) begin
         gap = int'($urandom_range(0, 4));
         if (prev_bad && gap == 0) gap = 1;
         repeat (gap) slot(1'b1);
         b  = 8'($urandom);
         ok = ($urandom_range(0, 4) != 0);
         expect_frame(b, ok);
         send_frame(b, ok, -1, 160);
         prev_bad = !ok;
      end
      repeat (4) slot(1'b1);
      settle();
      check_events("random");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for 8N1 frames: start bit (0), eight data bits LSB-first, stop bit (1). It oversamples the asynchronous serial input at 16× the baud rate, validates the start bit, and samples each data bit at mid-bit. It delivers each byte with a one-cycle valid strobe, or a one-cycle framing-error strobe if the stop bit is bad. It sits on the RX pin side of the UART, opposite the transmitter, and shares the baud generator with it.

## Interface
- `DATA_BITS`, default 8: data bits per frame; fixed at 8 for 8N1.
- `OVERSAMPLE`, default 16: ticks per bit period; fixed at 16.
- `clk` input, 1 bit: system clock; the only clock.
- `rst` input, 1 bit: asynchronous reset, active-high.
- `tick16` input, 1 bit: one-cycle pulse at 16× the baud rate, from the shared baud generator.
- `rx_line` input, 1 bit: serial RX line, asynchronous to `clk`; idles high.
- `rx_data` output, 8 bits: last correctly received byte; held until the next good frame.
- `rx_valid` output, 1 bit: one-cycle pulse when `rx_data` updates.
- `rx_frame_err` output, 1 bit: one-cycle pulse when the stop bit samples 0.
- `rx_busy` output, 1 bit: high from start-bit detection until the frame ends or is rejected.

## Operation
- **Input synchronization.** `rx_line` passes through a 2-flop synchronizer, reset value 1. All logic uses the synchronized value `rx_s`.
- **Sampling.** Samples are taken only on cycles where `tick16` is high. `os_cnt` is 4 bits, `bit_idx` is 3 bits, and `shift_reg` is 8 bits. `rx_s` is referred to as `rx_sample`, which is the raw value, or the voted value when the majority-vote feature is enabled.
- **State machine.**
  - **IDLE.** `rx_busy`=0. On a tick with `armed`=1 and `rx_s`=0: set `os_cnt`=0, `rx_busy`=1, go to START. On a tick with `rx_s`=1: set `armed`=1.
  - **START.** Each tick increments `os_cnt`. On the tick where `os_cnt`==7 (mid start bit):
    - if `rx_sample`=1, the start is false: return to IDLE, clear `rx_busy`, no strobe;
    - otherwise set `os_cnt`=0, `bit_idx`=0, go to DATA.
  - **DATA.** Each tick increments `os_cnt` modulo 16. On the tick where `os_cnt`==15, shift right with the sample entering the MSB: `shift_reg` <= {`rx_sample`, `shift_reg[7:1]`}. When `bit_idx`==7, go to STOP; otherwise increment `bit_idx`.
  - **STOP.** On the tick where `os_cnt`==15:
    - if `rx_sample`=1: `rx_data` <= `shift_reg` and pulse `rx_valid`;
    - otherwise pulse `rx_frame_err`, leave `rx_data` unchanged, and set `armed`=0.
    - In both cases clear `rx_busy` and go to IDLE.
- **Re-arming after a framing error.** After a framing error (break or noise), no new frame starts until the line has been seen high on at least one tick.
- **Reset values.** `rx_data`=0x00, `rx_valid`=0, `rx_frame_err`=0, `rx_busy`=0, state=IDLE, `armed`=1, `os_cnt`=0, `bit_idx`=0, `shift_reg`=0.
- **Reset mid-frame.** The frame is abandoned immediately with no strobe. If the line is still low after reset, that low is treated as a start edge.
- **Illegal state encoding.** Go to IDLE.

## Timing
- **Strobes.** `rx_valid` and `rx_frame_err` are registered and high for exactly one `clk` cycle, in the cycle after the stop-bit sampling tick. They are never high together.
- **Latency.** The stop bit is sampled 8 + 9×16 = 152 ticks after the tick that detected the start edge, plus 2 `clk` cycles of synchronizer delay relative to `rx_line`.
- **Back-to-back frames.** Frames with exactly one stop bit are accepted. IDLE can detect the next start on the first tick after returning from STOP.
- **Spacing between ticks.** No requirement; `tick16` may be high on consecutive cycles. Without a tick, all counters hold.

## Configuration
- `UART_RX_MAJORITY_EN` defined: `rx_sample` is the 2-of-3 majority of `rx_s` on the current tick and the two previous ticks, kept in a 2-bit tick-history register with reset value 2'b11. This applies to start validation, data bits and the stop bit.
- Not defined: `rx_sample` = `rx_s` on the sampling tick only, and the history register is absent.

## Structure
- **Shared package `uart_pkg`.** Holds the RX state encoding (IDLE, START, DATA, STOP), `DATA_BITS` = 8, `OVERSAMPLE` = 16, and the mid-start count 7, alongside the TX state constants.
- **Sub-module `uart_rx_sync`.** A 2-flop synchronizer with a reset value parameter, reusable for other asynchronous inputs.

## Test plan
- **Good frame.** Send 0xA5 at 16 ticks per bit → one `rx_valid` pulse with `rx_data`=0xA5, and `rx_busy` falls in the same cycle.
- **Start glitch.** Drive `rx_line` low for 4 ticks, then high → no `rx_valid` or `rx_frame_err`, `rx_busy` returns to 0 after `os_cnt`==7, and `rx_data` is unchanged.
- **Framing error.** Send 0x3C with the stop bit at 0 → `rx_frame_err` pulses once and `rx_data` keeps its previous value. Hold the line low for 40 more ticks → no new frame. Line high, then send 0x3C → `rx_valid` with 0x3C.
- **Back-to-back frames.** Send 0x00 then 0xFF with one stop bit each → two `rx_valid` pulses exactly 160 ticks apart, with data 0x00 then 0xFF.
- **Reset mid-frame.** Assert `rst` during bit 4 of 0x55 → all outputs return to their reset values. After release, send 0x81 → `rx_data`=0x81.
- **Single-tick glitch.** Flip the line for one tick at the bit-3 sample point of 0x0F → with `UART_RX_MAJORITY_EN`, `rx_data`=0x0F; without it, `rx_data`=0x07.
